// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage (master) and the multiply/divide unit (slave).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       MULOp;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output A, B, MULOp, start, input busy, HI, LO);
  modport slave  (input A, B, MULOp, start, output busy, HI, LO);
endinterface

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: fixed-latency multiply, restoring divider, mthi/mtlo.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are built only when MULDIV_MADD_EN is defined.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int MAX_CNT = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  state_e             state_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;

  logic               start_mul, start_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               mul_signed, div_signed, a_neg, b_neg;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;
  logic [WIDTH:0]     rem_shift, diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next, quo_next, div_hi, div_lo;

  // Start decode and operand magnitudes for the divider.
  always_comb begin
    start_mul = (bus.MULOp == OP_MULT) || (bus.MULOp == OP_MULTU);
`ifdef MULDIV_MADD_EN
    start_mul = start_mul || (bus.MULOp == OP_MADD) || (bus.MULOp == OP_MADDU) ||
                (bus.MULOp == OP_MSUB) || (bus.MULOp == OP_MSUBU);
`endif
    start_div = (bus.MULOp == OP_DIV) || (bus.MULOp == OP_DIVU);
    a_mag     = ((bus.MULOp == OP_DIV) && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag     = ((bus.MULOp == OP_DIV) && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  end

  // Multiply result, evaluated from the latched operands on the completion edge.
  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    a_ext      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod       = a_ext * b_ext;
    mul_res    = prod;
`ifdef MULDIV_MADD_EN
    if ((op_q == OP_MADD) || (op_q == OP_MADDU)) mul_res = {hi_q, lo_q} + prod;
    if ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) mul_res = {hi_q, lo_q} - prod;
`endif
  end

  // One restoring step per cycle; rem_q < divisor keeps the trial inside WIDTH+1 bits.
  always_comb begin
    rem_shift  = {rem_q, quo_q[WIDTH-1]};
    diff       = rem_shift - {1'b0, dvs_q};
    q_bit      = ~diff[WIDTH];
    rem_next   = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next   = {quo_q[WIDTH-2:0], q_bit};
    div_signed = (op_q == OP_DIV);
    a_neg      = div_signed & a_q[WIDTH-1];
    b_neg      = div_signed & b_q[WIDTH-1];
    div_lo     = (a_neg ^ b_neg) ? -quo_next : quo_next;
    div_hi     = a_neg ? -rem_next : rem_next;
    if (dvs_q == '0) begin
      div_hi = a_q;
      div_lo = '1;
    end else if (div_signed && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1)) begin
      div_hi = '0;
      div_lo = a_q;
    end
  end

  // NOTE: every register here is updated with <= so all reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (start_mul) begin
              op_q    <= bus.MULOp;
              a_q     <= bus.A;
              b_q     <= bus.B;
              cnt_q   <= CNT_W'(MUL_CYCLES);
              busy_q  <= 1'b1;
              state_q <= MUL;
            end else if (start_div) begin
              op_q    <= bus.MULOp;
              a_q     <= bus.A;
              b_q     <= bus.B;
              quo_q   <= a_mag;
              rem_q   <= '0;
              dvs_q   <= b_mag;
              cnt_q   <= CNT_W'(WIDTH);
              busy_q  <= 1'b1;
              state_q <= DIV;
            end else if (bus.MULOp == OP_MTHI) begin
              hi_q <= bus.A;
            end else if (bus.MULOp == OP_MTLO) begin
              lo_q <= bus.A;
            end
          end
        end
        MUL: begin
          if (cnt_q == CNT_W'(1)) begin
            {hi_q, lo_q} <= mul_res;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DIV: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= div_hi;
            lo_q    <= div_lo;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

  localparam int W  = 32;
  localparam int MC = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [W-1:0] hi_m, lo_m;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted op on {hi,lo}; lat is the expected busy length.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       inout logic [W-1:0] hi, inout logic [W-1:0] lo, output int lat);
    longint sp, up;
    int     sa, sb;
    logic [63:0] acc;
    sa  = a;
    sb  = b;
    sp  = longint'(sa) * longint'(sb);
    up  = longint'({32'd0, a}) * longint'({32'd0, b});
    acc = {hi, lo};
    lat = 0;
    case (op)
      4'd1: begin {hi, lo} = sp; lat = MC; end
      4'd2: begin {hi, lo} = up; lat = MC; end
      4'd3, 4'd4: begin
        lat = W;
        if (b == 0) begin
          hi = a; lo = '1;
        end else if (op == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = '0; lo = a;
        end else if (op == 4'd3) begin
          lo = sa / sb; hi = sa % sb;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      4'd5: hi = a;
      4'd6: lo = a;
`ifdef MULDIV_MADD_EN
      4'd7:  begin {hi, lo} = acc + sp; lat = MC; end
      4'd8:  begin {hi, lo} = acc + up; lat = MC; end
      4'd9:  begin {hi, lo} = acc - sp; lat = MC; end
      4'd10: begin {hi, lo} = acc - up; lat = MC; end
`endif
      default: ;
    endcase
  endtask

  // Entered and left just after a falling edge, so consecutive calls issue back-to-back.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int lat_exp, lat;
    logic [W-1:0] hi_old, lo_old;
    hi_old = hi_m;
    lo_old = lo_m;
    model(op, a, b, hi_m, lo_m, lat_exp);
    bus.A = a; bus.B = b; bus.MULOp = op; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.busy === 1'b1 && lat < 100) begin
      if (lat == 0) check({tag, ".hold"}, {bus.HI, bus.LO}, {hi_old, lo_old});
      lat++;
      @(negedge clk);
    end
    check({tag, ".busy"}, 64'(lat), 64'(lat_exp));
    check({tag, ".hilo"}, {bus.HI, bus.LO}, {hi_m, lo_m});
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'(1);
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    reset = 1'b1;
    bus.A = '0; bus.B = '0; bus.MULOp = '0; bus.start = 1'b0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.hilo", {bus.HI, bus.LO}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("multu5x3", 4'd2, 32'd5, 32'd3);
    run_op("mult-2x3", 4'd1, 32'hFFFF_FFFE, 32'd3);
    run_op("multu-2x3", 4'd2, 32'hFFFF_FFFE, 32'd3);
    run_op("divu7/2", 4'd4, 32'd7, 32'd2);
    run_op("div-7/2", 4'd3, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu9/0", 4'd4, 32'd9, 32'd0);
    run_op("div-5/0", 4'd3, 32'hFFFF_FFFB, 32'd0);
    run_op("mtlo", 4'd6, 32'h1234, 32'd0);
    run_op("mthi", 4'd5, 32'hABCD, 32'd0);
    run_op("mult5x3", 4'd1, 32'd5, 32'd3);
    run_op("madd2x4", 4'd7, 32'd2, 32'd4);
    run_op("mtlo0", 4'd6, 32'd0, 32'd0);
    run_op("mthi0", 4'd5, 32'd0, 32'd0);
    run_op("msubu1x1", 4'd10, 32'd1, 32'd1);
    run_op("nop15", 4'd15, 32'd7, 32'd7);

    // A divu pulsed on the second busy cycle of a multiply must be dropped.
    model(4'd1, 32'd4, 32'd4, hi_m, lo_m, lat);
    bus.A = 32'd4; bus.B = 32'd4; bus.MULOp = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.A = 32'd9; bus.B = 32'd2; bus.MULOp = 4'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 3;
    while (bus.busy === 1'b1 && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    check("ignore.busy", 64'(lat), 64'(MC + 1));
    check("ignore.hilo", {bus.HI, bus.LO}, {hi_m, lo_m});
    check("ignore.idle", 64'(bus.busy), 64'd0);

    // Reset on the tenth busy cycle of a divide discards it.
    bus.A = 32'd100; bus.B = 32'd7; bus.MULOp = 4'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_mid.busy10", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    check("rst_mid.busy", 64'(bus.busy), 64'd0);
    check("rst_mid.hilo", {bus.HI, bus.LO}, 64'd0);
    repeat (40) @(negedge clk);
    check("rst_mid.nowrite", {bus.HI, bus.LO}, 64'd0);

    for (int i = 0; i < 250; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d.op%0d", i, op), op, pick_operand(), pick_operand());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core; successor to the fixed 32-bit mult/div block.
- Holds the architectural HI/LO pair and executes mult/multu/div/divu/mthi/mtlo with a start/busy handshake toward the EX stage.
- Adds configurable width and multiply latency, a true iterative divider, defined divide-by-zero and overflow results, and optional multiply-accumulate ops.

Parameters:
- WIDTH, 32, operand and HI/LO width (>=4).
- MUL_CYCLES, 5, multiply latency in cycles, i.e. busy-high duration (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand rs (dividend / multiplicand / mthi-mtlo source).
- B  input  WIDTH  operand rt (divisor / multiplier).
- MULOp  input  4  operation code, sampled only when start=1.
- start  input  1  one-cycle request strobe.
- busy  output  1  high while a multi-cycle op is in progress.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- MULOp encoding:
  - 0 = nop, 1 = mult, 2 = multu, 3 = div, 4 = divu, 5 = mthi, 6 = mtlo.
  - 7 = madd, 8 = maddu, 9 = msub, 10 = msubu.
  - 11-15 = nop.
- Reset (any state): HI=0, LO=0, busy=0, FSM to IDLE. Any in-flight op is discarded without writing HI/LO.
- FSM states: IDLE, MUL, DIV.
- start is accepted only in IDLE with busy=0. start while busy is ignored; no queuing.
- mthi/mtlo:
  - Write HI (or LO) from A at the start edge.
  - busy never asserts; the other register is unchanged.
- Multiply ops (1, 2, 7-10):
  - A, B and MULOp are latched at the start edge; the FSM goes to MUL, busy=1, count = MUL_CYCLES.
  - After MUL_CYCLES edges, {HI,LO} is written with the 2*WIDTH-bit product (or accumulate), busy=0 on that same edge, and the FSM returns to IDLE.
  - busy is high for exactly MUL_CYCLES cycles.
- Signedness:
  - Signed ops sign-extend both operands to 2*WIDTH; unsigned ops zero-extend.
  - madd/maddu: {HI,LO} + product. msub/msubu: {HI,LO} - product.
  - Accumulate uses {HI,LO} as held at completion, wraps modulo 2^(2*WIDTH), and sets no flags.
- Divide ops (3, 4):
  - Restoring divider, one quotient bit per cycle, on magnitudes.
  - busy is high for exactly WIDTH cycles; result is written on the last edge, as for multiply.
  - LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (B=0), both signed and unsigned: HI = A, LO = all ones. Latency is unchanged.
- Signed overflow (A = most-negative, B = -1): LO = A, HI = 0.
- HI/LO hold their values at all times except the writes defined above. During busy, HI/LO show the old values.
- Back-to-back: start may be asserted on the cycle busy is first observed low, i.e. the cycle after the completion edge.
- busy is registered. The issuing stage must stall any mfhi/mflo while busy=1 or while start=1 that same cycle.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: ops 7-10 behave as specified above.
- Undefined: ops 7-10 are treated as nop. start with these codes is ignored, busy stays 0, HI/LO are unchanged, and no accumulate adder is synthesised.

Test Plan:
- Unsigned multiply, WIDTH=32, MUL_CYCLES=5: reset, then start multu A=5 B=3 -> busy high exactly 5 cycles, then HI=0x00000000, LO=0x0000000F.
- Signed multiply: mult A=0xFFFFFFFE (-2), B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- Divide:
  - divu 7/2 -> busy 32 cycles, then LO=3, HI=1.
  - div 0xFFFFFFF9 (-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero and mid-operation reset:
  - divu 9/0 -> HI=9, LO=0xFFFFFFFF.
  - Start div 100/7; assert reset at the 10th busy cycle -> next cycle busy=0, HI=0, LO=0. No later write occurs.
- Handshake and move ops:
  - Start mult 4×4; pulse start with divu on busy cycle 2 -> ignored, result HI=0, LO=16.
  - mtlo A=0x1234 -> LO=0x1234 next cycle, busy stays 0, HI unchanged.
- Accumulate with MULDIV_MADD_EN defined:
  - mult 5×3, then madd 2×4 -> HI=0, LO=23.
  - With HI=LO=0, msubu 1×1 -> HI=LO=0xFFFFFFFF.
  - With the macro undefined, madd -> no busy, HI/LO unchanged.
